ctrl_pipeline: RTL and testbench

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

---
 rtl/ctrl_pipeline.sv | 140 ++++++++++++++
 tb/tb_ctrl_pipeline.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: carries decoded control bits from Decode through the
// Execute, Memory and Writeback stages, inserts bubbles on stall, flush or
// taken branch, and keeps the architectural NZVC flag register.
// Optional macro CTRL_PIPE_PERF_EN adds the retiredCount and bubbleCount
// performance counters.
module ctrl_pipeline #(
  parameter int OPCODEWIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   writeEnableDD,
  input  logic                   writeDataEnableMD,
  input  logic                   resultSelectorWBD,
  input  logic                   data2SelectorED,
  input  logic                   outFlagIOD,
  input  logic [2:0]             aluControlED,
  input  logic [OPCODEWIDTH-1:0] opcodeD,
  input  logic                   validD,
  input  logic                   stallD,
  input  logic                   flushE,
  input  logic                   takeBranchE,
  input  logic                   NE,
  input  logic                   ZE,
  input  logic                   VE,
  input  logic                   CE,
  output logic [2:0]             aluControlE,
  output logic                   data2SelectorE,
  output logic [OPCODEWIDTH-1:0] opcodeE,
  output logic                   validE,
  output logic                   writeDataEnableM,
  output logic                   validM,
  output logic                   writeEnableW,
  output logic                   resultSelectorW,
  output logic                   outFlagIOW,
  output logic                   validW,
  output logic                   NE2,
  output logic                   ZE2,
  output logic                   VE2,
  output logic                   CE2,
  output logic                   flushD
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0]            retiredCount,
  output logic [31:0]            bubbleCount
`endif
);

  logic bubbleE;
  logic writeEnableE, writeDataEnableE, resultSelectorE, outFlagIOE;
  logic writeEnableM, resultSelectorM, outFlagIOM;

  // Any of these turns the next Execute slot into a bubble; a stall that
  // coincides with a flush or branch still yields exactly one bubble.
  assign bubbleE = stallD | flushE | takeBranchE;

  // A taken branch squashes the younger instructions in Fetch/Decode.
  assign flushD = takeBranchE;

  // Execute stage: load Decode controls, or clear everything on a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      writeEnableE     <= 1'b0;
      writeDataEnableE <= 1'b0;
      resultSelectorE  <= 1'b0;
      outFlagIOE       <= 1'b0;
      data2SelectorE   <= 1'b0;
      aluControlE      <= '0;
      opcodeE          <= '0;
      validE           <= 1'b0;
    end else if (bubbleE) begin
      writeEnableE     <= 1'b0;
      writeDataEnableE <= 1'b0;
      resultSelectorE  <= 1'b0;
      outFlagIOE       <= 1'b0;
      data2SelectorE   <= 1'b0;
      aluControlE      <= '0;
      opcodeE          <= '0;
      validE           <= 1'b0;
    end else begin
      writeEnableE     <= writeEnableDD;
      writeDataEnableE <= writeDataEnableMD;
      resultSelectorE  <= resultSelectorWBD;
      outFlagIOE       <= outFlagIOD;
      data2SelectorE   <= data2SelectorED;
      aluControlE      <= aluControlED;
      opcodeE          <= opcodeD;
      validE           <= validD;
    end
  end

  // Memory and Writeback stages never stall; enables are gated by valid so
  // a non-valid slot can never write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      writeEnableM     <= 1'b0;
      writeDataEnableM <= 1'b0;
      resultSelectorM  <= 1'b0;
      outFlagIOM       <= 1'b0;
      validM           <= 1'b0;
      writeEnableW     <= 1'b0;
      resultSelectorW  <= 1'b0;
      outFlagIOW       <= 1'b0;
      validW           <= 1'b0;
    end else begin
      writeEnableM     <= writeEnableE & validE;
      writeDataEnableM <= writeDataEnableE & validE;
      resultSelectorM  <= resultSelectorE;
      outFlagIOM       <= outFlagIOE;
      validM           <= validE;
      writeEnableW     <= writeEnableM & validM;
      resultSelectorW  <= resultSelectorM;
      outFlagIOW       <= outFlagIOM;
      validW           <= validM;
    end
  end

  // Flag register: captured from the Execute-stage ALU when that
  // instruction is real and writes; no bypass to the current cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {NE2, ZE2, VE2, CE2} <= 4'b0000;
    end else if (validE && writeEnableE) begin
      {NE2, ZE2, VE2, CE2} <= {NE, ZE, VE, CE};
    end
  end

`ifdef CTRL_PIPE_PERF_EN
  // Free-running performance counters; natural 32-bit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retiredCount <= '0;
      bubbleCount  <= '0;
    end else begin
      if (validW)  retiredCount <= retiredCount + 32'd1;
      if (bubbleE) bubbleCount  <= bubbleCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed scenarios plus randomized traffic,
// compared against a history-based model of the pipeline.
module tb_ctrl_pipeline;

  logic clk = 1'b0;
  logic rst_n;
  logic writeEnableDD, writeDataEnableMD, resultSelectorWBD, data2SelectorED, outFlagIOD;
  logic [2:0] aluControlED;
  logic [3:0] opcodeD;
  logic validD, stallD, flushE, takeBranchE;
  logic NE, ZE, VE, CE;
  logic [2:0] aluControlE;
  logic data2SelectorE;
  logic [3:0] opcodeE;
  logic validE, writeDataEnableM, validM;
  logic writeEnableW, resultSelectorW, outFlagIOW, validW;
  logic NE2, ZE2, VE2, CE2, flushD;
`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] retiredCount, bubbleCount;
  logic [31:0] retired_m, bubble_m;
`endif

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic       we;
    logic       wde;
    logic       rs;
    logic       d2s;
    logic       oio;
    logic [2:0] alu;
    logic [3:0] op;
    logic       v;
  } rec_t;

  // hist[i] is what entered Execute i edges before the most recent one's
  // predecessors: the last three entries are the W, M and E occupants.
  rec_t hist[$];
  logic [3:0] flags_m;

  ctrl_pipeline #(.OPCODEWIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .writeEnableDD(writeEnableDD), .writeDataEnableMD(writeDataEnableMD),
    .resultSelectorWBD(resultSelectorWBD), .data2SelectorED(data2SelectorED),
    .outFlagIOD(outFlagIOD), .aluControlED(aluControlED), .opcodeD(opcodeD),
    .validD(validD), .stallD(stallD), .flushE(flushE), .takeBranchE(takeBranchE),
    .NE(NE), .ZE(ZE), .VE(VE), .CE(CE),
    .aluControlE(aluControlE), .data2SelectorE(data2SelectorE), .opcodeE(opcodeE),
    .validE(validE), .writeDataEnableM(writeDataEnableM), .validM(validM),
    .writeEnableW(writeEnableW), .resultSelectorW(resultSelectorW),
    .outFlagIOW(outFlagIOW), .validW(validW),
    .NE2(NE2), .ZE2(ZE2), .VE2(VE2), .CE2(CE2), .flushD(flushD)
`ifdef CTRL_PIPE_PERF_EN
    , .retiredCount(retiredCount), .bubbleCount(bubbleCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back('0);
    flags_m = 4'b0000;
`ifdef CTRL_PIPE_PERF_EN
    retired_m = '0;
    bubble_m  = '0;
`endif
  endtask

  task automatic check_outputs();
    rec_t e, m, w;
    w = hist[0];
    m = hist[1];
    e = hist[2];
    chk("validE", 32'(validE), 32'(e.v));
    chk("opcodeE", 32'(opcodeE), 32'(e.op));
    chk("aluControlE", 32'(aluControlE), 32'(e.alu));
    chk("data2SelectorE", 32'(data2SelectorE), 32'(e.d2s));
    chk("validM", 32'(validM), 32'(m.v));
    chk("writeDataEnableM", 32'(writeDataEnableM), 32'(m.wde & m.v));
    chk("validW", 32'(validW), 32'(w.v));
    chk("writeEnableW", 32'(writeEnableW), 32'(w.we & w.v));
    chk("resultSelectorW", 32'(resultSelectorW), 32'(w.rs));
    chk("outFlagIOW", 32'(outFlagIOW), 32'(w.oio));
    chk("flags", 32'({NE2, ZE2, VE2, CE2}), 32'(flags_m));
`ifdef CTRL_PIPE_PERF_EN
    chk("retiredCount", retiredCount, retired_m);
    chk("bubbleCount", bubbleCount, bubble_m);
`endif
  endtask

  // One clock: inputs already driven; model advances across the edge.
  task automatic step();
    rec_t r;
    logic bub;
    chk("flushD", 32'(flushD), 32'(takeBranchE));
    bub = stallD | flushE | takeBranchE;
    r = '0;
    if (!bub) begin
      r.we  = writeEnableDD;
      r.wde = writeDataEnableMD;
      r.rs  = resultSelectorWBD;
      r.d2s = data2SelectorED;
      r.oio = outFlagIOD;
      r.alu = aluControlED;
      r.op  = opcodeD;
      r.v   = validD;
    end
    if (hist[2].v && hist[2].we) flags_m = {NE, ZE, VE, CE};
`ifdef CTRL_PIPE_PERF_EN
    if (hist[0].v) retired_m = retired_m + 32'd1;
    if (bub) bubble_m = bubble_m + 32'd1;
`endif
    @(posedge clk);
    hist.push_back(r);
    void'(hist.pop_front());
    #1;
    check_outputs();
  endtask

  task automatic clear_inputs();
    writeEnableDD = 0; writeDataEnableMD = 0; resultSelectorWBD = 0;
    data2SelectorED = 0; outFlagIOD = 0; aluControlED = 3'd0; opcodeD = 4'd0;
    validD = 0; stallD = 0; flushE = 0; takeBranchE = 0;
    NE = 0; ZE = 0; VE = 0; CE = 0;
  endtask

  task automatic random_inputs();
    writeEnableDD     = 1'($urandom);
    writeDataEnableMD = 1'($urandom);
    resultSelectorWBD = 1'($urandom);
    data2SelectorED   = 1'($urandom);
    outFlagIOD        = 1'($urandom);
    aluControlED      = 3'($urandom);
    opcodeD           = 4'($urandom);
    validD            = ($urandom_range(0, 3) != 0);
    stallD            = ($urandom_range(0, 5) == 0);
    flushE            = ($urandom_range(0, 9) == 0);
    takeBranchE       = ($urandom_range(0, 7) == 0);
    {NE, ZE, VE, CE}  = 4'($urandom);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Straight flow
    opcodeD = 4'h3; aluControlED = 3'b010; writeEnableDD = 1; validD = 1;
    step();
    chk("flow_opcodeE", 32'(opcodeE), 32'h3);
    clear_inputs();
    step();
    chk("flow_validM", 32'(validM), 32'd1);
    step();
    chk("flow_writeEnableW", 32'(writeEnableW), 32'd1);

    // Stall with a valid writing instruction behind a valid older one
    validD = 1; writeEnableDD = 1; opcodeD = 4'h9;
    step();
    stallD = 1;
    step();
    chk("stall_validE", 32'(validE), 32'd0);
    chk("stall_older_validM", 32'(validM), 32'd1);
    stallD = 0; validD = 0; writeEnableDD = 0;
    step();
    chk("stall_older_writeEnableW", 32'(writeEnableW), 32'd1);
    step();
    chk("stall_validW", 32'(validW), 32'd0);

    // Taken branch: E instruction completes, younger one squashed
    clear_inputs();
    validD = 1; opcodeD = 4'h5;
    step();
    takeBranchE = 1; opcodeD = 4'h6;
    chk("branch_flushD", 32'(flushD), 32'd1);
    step();
    chk("branch_validE", 32'(validE), 32'd0);
    chk("branch_validM", 32'(validM), 32'd1);

    // Flag write, then no write from a non-valid E slot
    clear_inputs();
    validD = 1; writeEnableDD = 1;
    step();
    validD = 0; writeEnableDD = 1;
    NE = 1; ZE = 0; VE = 1; CE = 0;
    step();
    chk("flags_written", 32'({NE2, ZE2, VE2, CE2}), 32'b1010);
    NE = 0; ZE = 1; VE = 0; CE = 1;
    step();
    chk("flags_held", 32'({NE2, ZE2, VE2, CE2}), 32'b1010);

    // Stall+branch together still a single bubble; three stalls in a row
    clear_inputs();
    validD = 1; stallD = 1; takeBranchE = 1;
    step();
    takeBranchE = 0;
    repeat (3) step();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      random_inputs();
      step();
    end

    // Asynchronous reset with valid instructions in flight
    clear_inputs();
    validD = 1; writeEnableDD = 1; writeDataEnableMD = 1;
    repeat (3) step();
    chk("pre_reset_validW", 32'(validW), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    reset_model();
    check_outputs();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    validD = 1; opcodeD = 4'hA;
    step();
    chk("post_reset_validE", 32'(validE), 32'd1);
    clear_inputs();
    repeat (3) step();

    for (int i = 0; i < 200; i++) begin
      random_inputs();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
